// File: rtl/log_arbiter.sv
// log_arbiter: severity-priority, round-robin arbiter sharing one log sink.
// Filters messages below cfg_verbosity and counts them in drop_cnt.
module log_arbiter #(
  parameter int NB_REQ = 4,
  parameter int ID_W   = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [2:0]                cfg_verbosity,
  input  logic [NB_REQ-1:0]         req_valid,
  output logic [NB_REQ-1:0]         req_ready,
  input  logic [3*NB_REQ-1:0]       req_level,
  input  logic [ID_W*NB_REQ-1:0]    req_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                out_level,
  output logic [ID_W-1:0]           out_id,
  output logic [$clog2(NB_REQ)-1:0] out_src,
  output logic [15:0]               drop_cnt
);

  localparam int SW = $clog2(NB_REQ);
  localparam logic [SW:0] NB_S = (SW+1)'(NB_REQ);

  typedef enum logic {EMPTY, FULL} slot_t;

  slot_t             state;
  logic [SW-1:0]     rr_ptr;
  logic [2:0]        clv [NB_REQ];
  logic [NB_REQ-1:0] drop;
  logic [NB_REQ-1:0] elig;
  logic [NB_REQ-1:0] gnt;
  logic [2:0]        max_lvl;
  logic [SW-1:0]     win;
  logic              found;
  logic              load;
  logic              grant;
  logic [SW:0]       s;
  logic [SW:0]       nx;
  logic [4:0]        pc;
  logic [16:0]       dsum;

  // Clamp levels 5..7 to 4 and classify each request
  always_comb begin
    for (int i = 0; i < NB_REQ; i++) begin
      clv[i]  = (req_level[3*i +: 3] > 3'd4) ? 3'd4 : req_level[3*i +: 3];
      drop[i] = clv[i] < cfg_verbosity;
      elig[i] = req_valid[i] & ~drop[i];
    end
  end

  // Highest clamped level wins; ties go to first index at/after rr_ptr
  always_comb begin
    max_lvl = '0;
    found   = 1'b0;
    win     = '0;
    s       = '0;
    for (int i = 0; i < NB_REQ; i++)
      if (elig[i] && clv[i] > max_lvl) max_lvl = clv[i];
    for (int k = 0; k < NB_REQ; k++) begin
      s = {1'b0, rr_ptr} + (SW+1)'(k);
      if (s >= NB_S) s = s - NB_S;
      if (!found && elig[s[SW-1:0]] && clv[s[SW-1:0]] == max_lvl) begin
        found = 1'b1;
        win   = s[SW-1:0];
      end
    end
  end

  assign load  = (state == EMPTY) | out_ready;
  assign grant = load & found;

  // Ready: the single winner plus every filtered request
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NB_REQ; i++)
      gnt[i] = grant & (win == SW'(i));
    req_ready = aresetn ? (gnt | (drop & req_valid)) : '0;
  end

  // Next pointer and saturating drop sum
  always_comb begin
    nx = {1'b0, win} + {{SW{1'b0}}, 1'b1};
    if (nx == NB_S) nx = '0;
    pc = '0;
    for (int i = 0; i < NB_REQ; i++)
      pc = pc + 5'(drop[i] & req_valid[i]);
    dsum = {1'b0, drop_cnt} + 17'(pc);
  end

  // Output slot FSM, round-robin pointer and drop counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_level <= '0;
      out_id    <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
      drop_cnt  <= '0;
    end else begin
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
      if (grant) begin
        state     <= FULL;
        out_valid <= 1'b1;
        out_level <= req_level[3*win +: 3];
        out_id    <= req_id[ID_W*win +: ID_W];
        out_src   <= win;
        rr_ptr    <= nx[SW-1:0];
      end else if (load) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/log_arbiter.md
# log_arbiter

Shares a single log-message sink between NB_REQ requesting blocks, such as FSMs that emit debug/info/warning/critical/error events, and delivers one message per cycle to the sink over a valid/ready channel. Messages below a runtime verbosity threshold are accepted and discarded, and counted in a saturating drop counter. Among eligible messages the highest severity wins. Ties are resolved round-robin. The block sits between the per-block event sources and the trace/logging sink.

## Interface
- NB_REQ, 4: number of requesters, 2..16.
- ID_W, 16: message identifier width.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_verbosity  in  3  minimum level forwarded.
- req_valid  in  NB_REQ  per-requester message valid.
- req_ready  out  NB_REQ  per-requester accept, combinational.
- req_level  in  3*NB_REQ  per-requester level. Slice i is [3i+2:3i].
- req_id  in  ID_W*NB_REQ  per-requester message id.
- out_valid  out  1  registered message valid.
- out_ready  in  1  sink accept.
- out_level  out  3  level of held message.
- out_id  out  ID_W  id of held message.
- out_src  out  $clog2(NB_REQ)  index of originating requester.
- drop_cnt  out  16  saturating count of filtered messages.

## Operation
- Levels: 0 debug, 1 info, 2 warning, 3 critical, 4 error. Values 5..7 are treated as 4 for both priority and filtering, and are forwarded unmodified on out_level.
- Filtering:
  - A request is droppable when its clamped level < cfg_verbosity.
  - A request is eligible when valid and not droppable.
  - All droppable requests get req_ready=1 in the same cycle, independent of output state.
- Output slot: single register with state EMPTY (out_valid=0) or FULL (out_valid=1).
  - load = EMPTY | (FULL & out_ready).
- Grant:
  - When load and any request is eligible, choose the eligible requester with the highest clamped level.
  - On a tie, choose the first tied index at or after rr_ptr, scanning upward with wrap.
  - The winner gets req_ready=1. Its level, id and index are registered into the slot next edge, and out_valid=1.
- Slot update:
  - load with no eligible request while FULL & out_ready: slot goes EMPTY.
  - FULL & ~out_ready: out_* holds stable, and no eligible request is acked.
- Round-robin pointer: rr_ptr = (winner+1) mod NB_REQ after each grant. There is one pointer shared across all levels. It is unchanged when there is no grant.
- drop_cnt:
  - Adds popcount(droppable & req_valid) each cycle.
  - Saturates at 0xFFFF and never wraps.
- cfg_verbosity is sampled combinationally every cycle. Changing it never affects a message already in the slot.
- Requesters must hold valid, level and id stable until ready. The arbiter does not check this.

## Timing
- Reset values:
  - out_valid=0, out_level=0, out_id=0, out_src=0, drop_cnt=0, rr_ptr=0, slot EMPTY.
  - req_ready=0 while aresetn=0.
- Latency: request accepted at edge N appears on out_* after edge N, i.e. one-cycle latency.
- Throughput: 1 message per cycle when out_ready stays high. The grant and the slot drain occur in the same cycle.
- Multiple acks per cycle: at most one eligible ack, plus any number of drop acks.
- Reset mid-operation: any held message is discarded and everything returns to reset values asynchronously. Requests pending at reset release are arbitrated from rr_ptr=0.
- No combinational path from out_ready to out_*. A combinational path from out_ready to req_ready is allowed.

## Test plan
- Reset with all 4 requesters valid at level 1 and cfg_verbosity=0, out_ready=1 -> grants in order 0,1,2,3,0; out_valid is high every cycle from the first grant.
- Req0 at level 1 and req2 at level 4 valid together, rr_ptr=0 -> req2 forwarded first with out_level=4 and out_src=2, then req0.
- cfg_verbosity=2, req1 at level 0 and req3 at level 3 -> req1 acked the same cycle; drop_cnt goes 0->1; only req3 appears on out_*, with out_level=3.
- out_ready held low for 5 cycles with message id 0xBEEF in the slot -> out_* stable for all 5 cycles, no eligible ack; after release, next grant on the same cycle.
- Force 65540 drops (all requesters below threshold) -> drop_cnt reaches 0xFFFF and holds.
- Assert aresetn=0 while FULL with out_ready=0 -> out_valid=0 immediately; after release the first grant comes from index 0.
